// File: rtl/brlite_local_port.sv
// Local input port of the BrLite router: accepts one broadcast message from the
// DMNI, fans it out to the enabled neighbour ports, then holds off for a guard interval.
module brlite_local_port #(
    parameter int DATA_SIZE   = 64,
    parameter int FWD_PORTS   = 4,
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    output logic                 ack_o,
    input  logic [DATA_SIZE-1:0] data_i,
    output logic                 local_busy_o,
    input  logic [FWD_PORTS-1:0] port_en_i,
    output logic [FWD_PORTS-1:0] fwd_req_o,
    input  logic [FWD_PORTS-1:0] fwd_ack_i,
    output logic [DATA_SIZE-1:0] fwd_data_o,
    output logic [CNT_WIDTH-1:0] bcast_cnt_o
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BCAST = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [FWD_PORTS-1:0] pending;
    logic [FWD_PORTS-1:0] pending_next;
    logic [FWD_PORTS-1:0] pending_cleared;
    logic [HOLD_W-1:0]    hold_cnt;
    logic [HOLD_W-1:0]    hold_cnt_next;
    logic [DATA_SIZE-1:0] data_q;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 transfer;
    logic                 bcast_done;

    assign ack_o        = req_i && (state == IDLE);
    assign transfer     = req_i && ack_o;
    assign local_busy_o = (state != IDLE);
    assign fwd_req_o    = (state == BCAST) ? pending : '0;
    assign fwd_data_o   = data_q;
    assign bcast_cnt_o  = cnt;

    // Acks only matter where a request is outstanding; stray bits fall away here.
    assign pending_cleared = pending & ~(fwd_ack_i & fwd_req_o);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        pending_next  = pending;
        hold_cnt_next = hold_cnt;
        bcast_done    = 1'b0;
        case (state)
            IDLE: begin
                if (transfer) begin
                    pending_next = port_en_i;
                    if (port_en_i != '0) begin
                        state_next = BCAST;
                    end else begin
                        state_next    = HOLD;
                        hold_cnt_next = HOLD_LOAD;
                    end
                end
            end
            BCAST: begin
                pending_next = pending_cleared;
                if (pending_cleared == '0) begin
                    state_next    = HOLD;
                    hold_cnt_next = HOLD_LOAD;
                    bcast_done    = 1'b1;
                end
            end
            HOLD: begin
                hold_cnt_next = hold_cnt - HOLD_W'(1);
                if (hold_cnt <= HOLD_W'(1)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending  <= '0;
            hold_cnt <= '0;
            data_q   <= '0;
            cnt      <= '0;
        end else begin
            pending  <= pending_next;
            hold_cnt <= hold_cnt_next;
            if (transfer) begin
                data_q <= data_i;
            end
            if (bcast_done) begin
                cnt <= cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_brlite_local_port.sv
// Directed bench for brlite_local_port; counter narrowed so wrap-around is reachable.
module tb_brlite_local_port;

    localparam int DW = 64;
    localparam int FP = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic          ack;
    logic [DW-1:0] data;
    logic          busy;
    logic [FP-1:0] port_en;
    logic [FP-1:0] fwd_req;
    logic [FP-1:0] fwd_ack;
    logic [DW-1:0] fwd_data;
    logic [CW-1:0] cnt;

    logic [CW-1:0] exp_cnt;
    int checks = 0;
    int errors = 0;

    brlite_local_port #(
        .DATA_SIZE(DW), .FWD_PORTS(FP), .HOLD_CYCLES(4), .CNT_WIDTH(CW)
    ) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .ack_o(ack), .data_i(data),
        .local_busy_o(busy), .port_en_i(port_en), .fwd_req_o(fwd_req),
        .fwd_ack_i(fwd_ack), .fwd_data_o(fwd_data), .bcast_cnt_o(cnt)
    );

    always #5 clk = ~clk;

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle;
        int n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 20) begin
            next_cycle();
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL wait_idle: busy=%b want 0", busy); end
        next_cycle();
    endtask

    task automatic test_reset;
        rst = 1'b1; req = 1'b0; data = '0; port_en = '0; fwd_ack = '0;
        next_cycle();
        @(negedge clk);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", ack); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (fwd_req !== 4'b0000) begin errors++; $display("FAIL reset_fwd_req: got %b want 0000", fwd_req); end
        checks++; if (fwd_data !== 64'h0) begin errors++; $display("FAIL reset_fwd_data: got %h want 0", fwd_data); end
        checks++; if (cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
        next_cycle();
        rst = 1'b0;
        exp_cnt = '0;
    endtask

    task automatic test_basic;
        int n;
        req = 1'b1; data = 64'hA5; port_en = 4'b1111; fwd_ack = 4'b0000;
        @(negedge clk);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL basic_ack: got %b want 1", ack); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_idle: got %b want 0", busy); end
        next_cycle();
        req = 1'b0; fwd_ack = 4'b1111;
        @(negedge clk);
        checks++; if (fwd_req !== 4'b1111) begin errors++; $display("FAIL basic_fwd_req: got %b want 1111", fwd_req); end
        checks++; if (fwd_data !== 64'hA5) begin errors++; $display("FAIL basic_fwd_data: got %h want a5", fwd_data); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL basic_ack_once: got %b want 0", ack); end
        next_cycle();
        fwd_ack = 4'b0000; req = 1'b1; data = 64'hB6; port_en = 4'b0000;
        exp_cnt = exp_cnt + 1'b1;
        @(negedge clk);
        checks++; if (fwd_req !== 4'b0000) begin errors++; $display("FAIL basic_req_drop: got %b want 0000", fwd_req); end
        checks++; if (cnt !== exp_cnt) begin errors++; $display("FAIL basic_cnt: got %0d want %0d", cnt, exp_cnt); end
        n = 0;
        while (ack !== 1'b1 && n < 10) begin
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_hold_busy: got %b want 1", busy); end
            next_cycle();
            @(negedge clk);
            n++;
        end
        checks++; if (n !== 4) begin errors++; $display("FAIL basic_hold_len: got %0d want 4", n); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_again: got %b want 0", busy); end
        checks++; if (fwd_data !== 64'hA5) begin errors++; $display("FAIL basic_data_kept: got %h want a5", fwd_data); end
        next_cycle();
        req = 1'b0;
        wait_idle();
    endtask

    task automatic test_partial;
        req = 1'b1; data = 64'hC3; port_en = 4'b0101; fwd_ack = 4'b0000;
        @(negedge clk);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL partial_ack: got %b want 1", ack); end
        next_cycle();
        req = 1'b0; port_en = 4'b1111;
        @(negedge clk);
        checks++; if (fwd_req !== 4'b0101) begin errors++; $display("FAIL partial_c1: got %b want 0101", fwd_req); end
        next_cycle();
        fwd_ack = 4'b0001;
        @(negedge clk);
        checks++; if (fwd_req !== 4'b0101) begin errors++; $display("FAIL partial_c2: got %b want 0101", fwd_req); end
        next_cycle();
        fwd_ack = 4'b0000;
        @(negedge clk);
        checks++; if (fwd_req !== 4'b0100) begin errors++; $display("FAIL partial_c3: got %b want 0100", fwd_req); end
        next_cycle();
        @(negedge clk);
        checks++; if (fwd_req !== 4'b0100) begin errors++; $display("FAIL partial_c4: got %b want 0100", fwd_req); end
        checks++; if (cnt !== exp_cnt) begin errors++; $display("FAIL partial_cnt_early: got %0d want %0d", cnt, exp_cnt); end
        next_cycle();
        fwd_ack = 4'b0100;
        @(negedge clk);
        checks++; if (fwd_req !== 4'b0100) begin errors++; $display("FAIL partial_c5: got %b want 0100", fwd_req); end
        next_cycle();
        fwd_ack = 4'b0000;
        exp_cnt = exp_cnt + 1'b1;
        @(negedge clk);
        checks++; if (fwd_req !== 4'b0000) begin errors++; $display("FAIL partial_c6: got %b want 0000", fwd_req); end
        checks++; if (cnt !== exp_cnt) begin errors++; $display("FAIL partial_cnt: got %0d want %0d", cnt, exp_cnt); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL partial_busy: got %b want 1", busy); end
        wait_idle();
    endtask

    task automatic test_zero_enable;
        int n;
        req = 1'b1; data = 64'hD4; port_en = 4'b0000;
        @(negedge clk);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL zero_ack: got %b want 1", ack); end
        next_cycle();
        req = 1'b0;
        @(negedge clk);
        checks++; if (fwd_req !== 4'b0000) begin errors++; $display("FAIL zero_fwd_req: got %b want 0000", fwd_req); end
        checks++; if (fwd_data !== 64'hD4) begin errors++; $display("FAIL zero_data: got %h want d4", fwd_data); end
        n = 0;
        while (busy === 1'b1 && n < 10) begin
            next_cycle();
            @(negedge clk);
            n++;
        end
        checks++; if (n !== 4) begin errors++; $display("FAIL zero_hold_len: got %0d want 4", n); end
        checks++; if (cnt !== exp_cnt) begin errors++; $display("FAIL zero_cnt: got %0d want %0d", cnt, exp_cnt); end
        next_cycle();
    endtask

    task automatic test_back_to_back;
        int n;
        req = 1'b1; data = 64'h1; port_en = 4'b0011; fwd_ack = 4'b0000;
        @(negedge clk);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL b2b_ack1: got %b want 1", ack); end
        next_cycle();
        data = 64'h2;
        @(negedge clk);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL b2b_ack_bcast: got %b want 0", ack); end
        checks++; if (fwd_req !== 4'b0011) begin errors++; $display("FAIL b2b_fwd_req: got %b want 0011", fwd_req); end
        checks++; if (fwd_data !== 64'h1) begin errors++; $display("FAIL b2b_data1: got %h want 1", fwd_data); end
        next_cycle();
        fwd_ack = 4'b0011;
        @(negedge clk);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL b2b_ack_bcast2: got %b want 0", ack); end
        checks++; if (fwd_data !== 64'h1) begin errors++; $display("FAIL b2b_data1b: got %h want 1", fwd_data); end
        next_cycle();
        fwd_ack = 4'b0000;
        exp_cnt = exp_cnt + 1'b1;
        @(negedge clk);
        n = 0;
        while (ack !== 1'b1 && n < 10) begin
            next_cycle();
            @(negedge clk);
            n++;
        end
        checks++; if (n !== 4) begin errors++; $display("FAIL b2b_wait_len: got %0d want 4", n); end
        checks++; if (fwd_data !== 64'h1) begin errors++; $display("FAIL b2b_data1c: got %h want 1", fwd_data); end
        checks++; if (cnt !== exp_cnt) begin errors++; $display("FAIL b2b_cnt1: got %0d want %0d", cnt, exp_cnt); end
        next_cycle();
        req = 1'b0; fwd_ack = 4'b0011;
        @(negedge clk);
        checks++; if (fwd_req !== 4'b0011) begin errors++; $display("FAIL b2b_fwd_req2: got %b want 0011", fwd_req); end
        checks++; if (fwd_data !== 64'h2) begin errors++; $display("FAIL b2b_data2: got %h want 2", fwd_data); end
        next_cycle();
        fwd_ack = 4'b0000;
        exp_cnt = exp_cnt + 1'b1;
        @(negedge clk);
        checks++; if (cnt !== exp_cnt) begin errors++; $display("FAIL b2b_cnt2: got %0d want %0d", cnt, exp_cnt); end
        wait_idle();
    endtask

    task automatic test_spurious_ack;
        int n;
        req = 1'b0; fwd_ack = 4'b1111;
        @(negedge clk);
        checks++; if (fwd_req !== 4'b0000) begin errors++; $display("FAIL spur_idle_req: got %b want 0000", fwd_req); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL spur_idle_busy: got %b want 0", busy); end
        next_cycle();
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL spur_idle_busy2: got %b want 0", busy); end
        checks++; if (cnt !== exp_cnt) begin errors++; $display("FAIL spur_idle_cnt: got %0d want %0d", cnt, exp_cnt); end
        next_cycle();
        fwd_ack = 4'b0000; req = 1'b1; data = 64'hE5; port_en = 4'b0000;
        @(negedge clk);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL spur_ack: got %b want 1", ack); end
        next_cycle();
        req = 1'b0; fwd_ack = 4'b1111;
        @(negedge clk);
        checks++; if (fwd_req !== 4'b0000) begin errors++; $display("FAIL spur_hold_req: got %b want 0000", fwd_req); end
        n = 0;
        while (busy === 1'b1 && n < 10) begin
            next_cycle();
            @(negedge clk);
            n++;
        end
        checks++; if (n !== 4) begin errors++; $display("FAIL spur_hold_len: got %0d want 4", n); end
        checks++; if (cnt !== exp_cnt) begin errors++; $display("FAIL spur_hold_cnt: got %0d want %0d", cnt, exp_cnt); end
        next_cycle();
        fwd_ack = 4'b0000;
    endtask

    task automatic test_mid_reset;
        req = 1'b1; data = 64'h77; port_en = 4'b0011; fwd_ack = 4'b0000;
        @(negedge clk);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rst_ack1: got %b want 1", ack); end
        next_cycle();
        req = 1'b0;
        @(negedge clk);
        checks++; if (fwd_req !== 4'b0011) begin errors++; $display("FAIL rst_pending: got %b want 0011", fwd_req); end
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0; req = 1'b1; data = 64'h88; port_en = 4'b1111;
        exp_cnt = '0;
        @(negedge clk);
        checks++; if (fwd_req !== 4'b0000) begin errors++; $display("FAIL rst_fwd_req: got %b want 0000", fwd_req); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (cnt !== 4'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", cnt); end
        checks++; if (fwd_data !== 64'h0) begin errors++; $display("FAIL rst_data: got %h want 0", fwd_data); end
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rst_new_ack: got %b want 1", ack); end
        next_cycle();
        req = 1'b0; fwd_ack = 4'b1111;
        @(negedge clk);
        checks++; if (fwd_req !== 4'b1111) begin errors++; $display("FAIL rst_new_req: got %b want 1111", fwd_req); end
        checks++; if (fwd_data !== 64'h88) begin errors++; $display("FAIL rst_new_data: got %h want 88", fwd_data); end
        next_cycle();
        fwd_ack = 4'b0000;
        exp_cnt = exp_cnt + 1'b1;
        @(negedge clk);
        checks++; if (cnt !== exp_cnt) begin errors++; $display("FAIL rst_new_cnt: got %0d want %0d", cnt, exp_cnt); end
        wait_idle();
    endtask

    task automatic test_wrap;
        for (int i = 0; i < 15; i++) begin
            req = 1'b1; data = 64'(i + 16'h100); port_en = 4'b1111;
            next_cycle();
            req = 1'b0; fwd_ack = 4'b1111;
            next_cycle();
            fwd_ack = 4'b0000;
            exp_cnt = exp_cnt + 1'b1;
            @(negedge clk);
            checks++; if (cnt !== exp_cnt) begin errors++; $display("FAIL wrap_cnt_%0d: got %0d want %0d", i, cnt, exp_cnt); end
            wait_idle();
        end
        checks++; if (cnt !== 4'd0) begin errors++; $display("FAIL wrap_zero: got %0d want 0", cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_partial();
        test_zero_enable();
        test_back_to_back();
        test_spurious_ack();
        test_mid_reset();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
